// File: rtl/ysyx_22040386_mdu_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit:
// funct3 encodings, FSM state type and the 32-bit sign-extension helper.
package ysyx_22040386_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mdu_state_e;

  // Callers slice the low XLEN bits, so one helper serves both XLEN=32 and 64.
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22040386_mdu_if.sv
// Op/result handshake bundle between the execute stage (master) and the MDU (slave).
interface ysyx_22040386_mdu_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic             in_word;
  logic [XLEN-1:0]  in_src1;
  logic [XLEN-1:0]  in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_funct3, in_word, in_src1, in_src2, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  in_valid, in_funct3, in_word, in_src1, in_src2, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/ysyx_22040386_mdu_core.sv
// Iterative datapath: one shared {hi,lo} register doing radix-2 shift-add
// multiply or restoring division on operand magnitudes, plus the step counter.
module ysyx_22040386_mdu_core #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_isDiv,
  input  logic            i_word,
  input  logic            i_skip,
  input  logic [XLEN-1:0] i_opA,
  input  logic [XLEN-1:0] i_opB,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo,
  output logic            o_done
);
  localparam int CW     = $clog2(XLEN) + 1;
  localparam int WSHIFT = XLEN - 32;

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opA;
  logic            r_isDiv;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_limit;

  logic [CW-1:0]   w_limit;
  logic [XLEN:0]   w_mulSum;
  logic [XLEN:0]   w_divShift;
  logic [XLEN:0]   w_divDiff;
  logic            w_divFits;

  assign w_limit    = (i_word || XLEN == 32) ? CW'(32) : CW'(XLEN);
  assign w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opA} : '0);
  // Partial remainder stays below the divisor, so the XLEN+1 bit difference never wraps.
  assign w_divShift = {r_hi, r_lo[XLEN-1]};
  assign w_divDiff  = w_divShift - {1'b0, r_opA};
  assign w_divFits  = ~w_divDiff[XLEN];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_opA   <= '0;
      r_isDiv <= 1'b0;
      r_count <= '0;
      r_limit <= '0;
    end else if (i_load) begin
      r_hi    <= '0;
      // Word divides left-align the dividend so its MSB is shifted out first.
      r_lo    <= (i_isDiv && i_word) ? (i_opB << WSHIFT) : i_opB;
      r_opA   <= i_opA;
      r_isDiv <= i_isDiv;
      r_limit <= w_limit;
      r_count <= i_skip ? w_limit : '0;
    end else if (i_step && !o_done) begin
      if (r_isDiv) begin
        r_hi <= w_divFits ? w_divDiff[XLEN-1:0] : w_divShift[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_divFits};
      end else begin
        {r_hi, r_lo} <= {w_mulSum, r_lo[XLEN-1:1]};
      end
      r_count <= r_count + CW'(1);
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_done = (r_count == r_limit);

endmodule

// File: rtl/ysyx_22040386_mdu.sv
// RV64M multiply/divide unit: FSM, handshake, sign fix-up and output register around the core.
// Optional YSYX_MDU_DIV_FAST_EN: divide special cases (zero, MIN/-1, divisor 1) finish without iterating.
module ysyx_22040386_mdu
  import ysyx_22040386_mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  ysyx_22040386_mdu_if.slave bus
);
  localparam int          WSHIFT  = XLEN - 32;
  localparam logic [63:0] MIN_W64 = 64'hFFFF_FFFF_8000_0000;

  mdu_state_e       r_state;
  logic [2:0]       r_f3;
  logic             r_word;
  logic [TAG_W-1:0] r_tag;
  logic             r_negQ;
  logic             r_negR;
  logic             r_divZero;
  logic             r_overflow;
  logic [XLEN-1:0]  r_dividend;
  logic             r_outValid;
  logic [XLEN-1:0]  r_outResult;
  logic [TAG_W-1:0] r_outTag;

  logic             w_word;
  logic             w_isDiv;
  logic             w_sgnA;
  logic             w_sgnB;
  logic             w_negA;
  logic             w_negB;
  logic             w_divZero;
  logic             w_overflow;
  logic             w_load;
  logic             w_skip;
  logic             w_coreDone;
  logic [63:0]      w_sx1;
  logic [63:0]      w_sx2;
  logic [XLEN-1:0]  w_a;
  logic [XLEN-1:0]  w_b;
  logic [XLEN-1:0]  w_magA;
  logic [XLEN-1:0]  w_magB;
  logic [XLEN-1:0]  w_minVal;
  logic [XLEN-1:0]  w_hi;
  logic [XLEN-1:0]  w_lo;
  logic [2*XLEN-1:0] w_prodRaw;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]  w_quot;
  logic [XLEN-1:0]  w_rem;
  logic [XLEN-1:0]  w_res;
  logic [63:0]      w_sxRes;
  logic [XLEN-1:0]  w_final;

  assign w_word = (XLEN == 64) ? bus.in_word : 1'b0;
  assign w_sx1  = sext32(bus.in_src1[31:0]);
  assign w_sx2  = sext32(bus.in_src2[31:0]);

  // Operand extension and magnitude for the accepting op; MULHSU leaves rs2 unsigned.
  always_comb begin
    w_isDiv = bus.in_funct3[2];
    w_sgnA  = w_isDiv ? ~bus.in_funct3[0] : (bus.in_funct3 != MDU_MULHU);
    w_sgnB  = w_isDiv ? ~bus.in_funct3[0]
                      : (bus.in_funct3 == MDU_MUL || bus.in_funct3 == MDU_MULH);
    if (w_word) begin
      w_a      = w_sgnA ? w_sx1[XLEN-1:0] : XLEN'(bus.in_src1[31:0]);
      w_b      = w_sgnB ? w_sx2[XLEN-1:0] : XLEN'(bus.in_src2[31:0]);
      w_minVal = MIN_W64[XLEN-1:0];
    end else begin
      w_a      = bus.in_src1;
      w_b      = bus.in_src2;
      w_minVal = {1'b1, {(XLEN-1){1'b0}}};
    end
    w_negA     = w_sgnA & w_a[XLEN-1];
    w_negB     = w_sgnB & w_b[XLEN-1];
    w_magA     = w_negA ? -w_a : w_a;
    w_magB     = w_negB ? -w_b : w_b;
    w_divZero  = (w_b == '0);
    w_overflow = ~bus.in_funct3[0] & (w_a == w_minVal) & (w_b == '1);
  end

  assign w_load = (r_state == IDLE) & bus.in_valid & ~flush;

`ifdef YSYX_MDU_DIV_FAST_EN
  logic w_divOne;
  logic r_divOne;
  assign w_divOne = (w_b == XLEN'(1));
  assign w_skip   = w_isDiv & (w_divZero | w_overflow | w_divOne);
`else
  assign w_skip   = 1'b0;
`endif

  ysyx_22040386_mdu_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_step (r_state == BUSY),
    .i_isDiv(w_isDiv),
    .i_word (w_word),
    .i_skip (w_skip),
    .i_opA  (w_magB),
    .i_opB  (w_magA),
    .o_hi   (w_hi),
    .o_lo   (w_lo),
    .o_done (w_coreDone)
  );

  // Final stage: undo magnitudes, force RISC-V special results, pick the field, word-extend.
  always_comb begin
    w_prodRaw = {w_hi, w_lo} >> (r_word ? WSHIFT : 0);
    w_prod    = r_negQ ? -w_prodRaw : w_prodRaw;
    w_quot    = r_negQ ? -w_lo : w_lo;
    w_rem     = r_negR ? -w_hi : w_hi;
    if (r_divZero) begin
      w_quot = '1;
      w_rem  = r_dividend;
    end else if (r_overflow) begin
      w_quot = r_dividend;
      w_rem  = '0;
    end
`ifdef YSYX_MDU_DIV_FAST_EN
    else if (r_divOne) begin
      w_quot = r_dividend;
      w_rem  = '0;
    end
`endif
    unique case (r_f3)
      MDU_MUL:                        w_res = w_prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: w_res = w_prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              w_res = w_quot;
      default:                        w_res = w_rem;
    endcase
    w_sxRes = sext32(w_res[31:0]);
    w_final = r_word ? w_sxRes[XLEN-1:0] : w_res;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_f3        <= '0;
      r_word      <= 1'b0;
      r_tag       <= '0;
      r_negQ      <= 1'b0;
      r_negR      <= 1'b0;
      r_divZero   <= 1'b0;
      r_overflow  <= 1'b0;
      r_dividend  <= '0;
      r_outValid  <= 1'b0;
      r_outResult <= '0;
      r_outTag    <= '0;
`ifdef YSYX_MDU_DIV_FAST_EN
      r_divOne    <= 1'b0;
`endif
    end else if (flush) begin
      r_state    <= IDLE;
      r_outValid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_state    <= BUSY;
            r_f3       <= bus.in_funct3;
            r_word     <= w_word;
            r_tag      <= bus.in_tag;
            r_negQ     <= w_negA ^ w_negB;
            r_negR     <= w_negA;
            r_divZero  <= w_isDiv & w_divZero;
            r_overflow <= w_isDiv & w_overflow;
            r_dividend <= w_a;
`ifdef YSYX_MDU_DIV_FAST_EN
            r_divOne   <= w_isDiv & w_divOne;
`endif
          end
        end
        BUSY: begin
          if (w_coreDone) begin
            r_state     <= DONE;
            r_outValid  <= 1'b1;
            r_outResult <= w_final;
            r_outTag    <= r_tag;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.out_valid  = r_outValid;
  assign bus.out_result = r_outResult;
  assign bus.out_tag    = r_outTag;

endmodule

// File: tb/tb_ysyx_22040386_mdu.sv
// Directed self-checking bench for ysyx_22040386_mdu (XLEN=64): arithmetic vectors,
// latency, handshake hold, flush and reset-in-DONE.
module tb_ysyx_22040386_mdu;
  import ysyx_22040386_mdu_pkg::*;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;
`ifdef YSYX_MDU_DIV_FAST_EN
  localparam bit FAST_BUILD = 1'b1;
`else
  localparam bit FAST_BUILD = 1'b0;
`endif
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ysyx_22040386_mdu_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  ysyx_22040386_mdu #(
    .XLEN (XLEN),
    .TAG_W(TAG_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%h expected=0x%h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f3, input logic w, input logic [63:0] a,
                               input logic [63:0] b, input logic [4:0] t);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_funct3 = f3;
    bus.in_word   = w;
    bus.in_src1   = a;
    bus.in_src2   = b;
    bus.in_tag    = t;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic takeResult();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] t,
                       input logic [63:0] exp, input bit fastCase);
    int lat;
    int expLat;
    applyStimulus(f3, w, a, b, t);
    waitValid(lat);
    expLat = (FAST_BUILD && fastCase) ? 1 : (w ? 33 : 65);
    checkOutput({name, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({name, " result"}, bus.out_result, exp);
    checkOutput({name, " tag"}, 64'(bus.out_tag), 64'(t));
    takeResult();
  endtask

  initial begin
    int lat;
    bit rose;
    bus.in_valid  = 1'b0;
    bus.in_funct3 = '0;
    bus.in_word   = 1'b0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset out_result", bus.out_result, 64'd0);
    checkOutput("reset out_tag", 64'(bus.out_tag), 64'd0);
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("MUL 7*-3", MDU_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'h15, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    runOp("MULHU", MDU_MULHU, 1'b0, ONES, 64'd2, 5'h01, 64'd1, 1'b0);
    runOp("MULH", MDU_MULH, 1'b0, ONES, 64'd2, 5'h02, ONES, 1'b0);
    runOp("MULHSU", MDU_MULHSU, 1'b0, 64'd2, ONES, 5'h03, 64'd1, 1'b0);
    runOp("MUL big", MDU_MUL, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 5'h04, 64'h2_0000_0001, 1'b0);
    runOp("MULHU big", MDU_MULHU, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 5'h05, 64'd1, 1'b0);
    runOp("DIV -7/2", MDU_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'h06, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    runOp("REM -7/2", MDU_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'h07, ONES, 1'b0);
    runOp("DIV 7/-2", MDU_DIV, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'h08, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    runOp("REM 7/-2", MDU_REM, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'h09, 64'd1, 1'b0);
    runOp("DIVU 100/7", MDU_DIVU, 1'b0, 64'd100, 64'd7, 5'h0A, 64'd14, 1'b0);
    runOp("REMU 100/7", MDU_REMU, 1'b0, 64'd100, 64'd7, 5'h0B, 64'd2, 1'b0);
    runOp("DIVU 5/0", MDU_DIVU, 1'b0, 64'd5, 64'd0, 5'h0C, ONES, 1'b1);
    runOp("REMU 5/0", MDU_REMU, 1'b0, 64'd5, 64'd0, 5'h0D, 64'd5, 1'b1);
    runOp("DIV MIN/-1", MDU_DIV, 1'b0, MIN64, ONES, 5'h0E, MIN64, 1'b1);
    runOp("REM MIN/-1", MDU_REM, 1'b0, MIN64, ONES, 5'h0F, 64'd0, 1'b1);
    runOp("DIVW MIN/1", MDU_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 5'h10, 64'hFFFF_FFFF_8000_0000, 1'b1);
    runOp("MULW 2^16*2^16", MDU_MUL, 1'b1, 64'h1_0000, 64'h1_0000, 5'h11, 64'd0, 1'b0);
    runOp("MULW -1*3", MDU_MUL, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd3, 5'h12, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    runOp("DIVUW", MDU_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 5'h13, 64'h0000_0000_7FFF_FFFF, 1'b0);
    runOp("REMUW", MDU_REMU, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h10, 5'h14, 64'd9, 1'b0);
    runOp("REMW -7/2", MDU_REM, 1'b1, 64'hAAAA_AAAA_FFFF_FFF9, 64'd2, 5'h16, ONES, 1'b0);
    runOp("DIVW x/0", MDU_DIV, 1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, 5'h17, ONES, 1'b1);

    // Result must hold while the consumer stalls; new ops are refused meanwhile.
    applyStimulus(MDU_MUL, 1'b0, 64'd3, 64'd4, 5'h07);
    waitValid(lat);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("hold out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("hold out_result", bus.out_result, 64'd12);
    checkOutput("hold out_tag", 64'(bus.out_tag), 64'd7);
    checkOutput("hold in_ready", 64'(bus.in_ready), 64'd0);
    takeResult();
    checkOutput("taken out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("taken in_ready", 64'(bus.in_ready), 64'd1);

    // An op offered while busy is ignored.
    applyStimulus(MDU_MUL, 1'b0, 64'd6, 64'd7, 5'h01);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_src1  = 64'd100;
    bus.in_src2  = 64'd100;
    bus.in_tag   = 5'h02;
    waitValid(lat);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("ignore result", bus.out_result, 64'd42);
    checkOutput("ignore tag", 64'(bus.out_tag), 64'd1);
    takeResult();

    applyStimulus(MDU_MUL, 1'b0, 64'd9, 64'd9, 5'h03);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush busy", 64'(bus.busy), 64'd0);
    checkOutput("flush in_ready", 64'(bus.in_ready), 64'd1);
    rose = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) rose = 1'b1;
    end
    checkOutput("flush no out_valid", 64'(rose), 64'd0);

    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_funct3 = MDU_MUL;
    flush         = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    checkOutput("flush+valid busy", 64'(bus.busy), 64'd0);

    applyStimulus(MDU_MUL, 1'b0, 64'd3, 64'd4, 5'h1F);
    waitValid(lat);
    checkOutput("pre-reset out_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstDone out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rstDone out_result", bus.out_result, 64'd0);
    checkOutput("rstDone out_tag", 64'(bus.out_tag), 64'd0);
    checkOutput("rstDone busy", 64'(bus.busy), 64'd0);
    checkOutput("rstDone in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
